uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the bit-period divisor.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port en_i  input  1  receiver enable.
REQ-005 SHALL have port div_i  input  DIV_W  clk cycles per UART bit.
REQ-006 SHALL have port rx_i  input  1  serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port data_o  output  8  received byte.
REQ-008 SHALL have port valid_o  output  1  data_o holds an unread byte.
REQ-009 SHALL have port ready_i  input  1  consumer accepts data_o when valid_o=1.
REQ-010 SHALL have port frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port overrun_o  output  1  one-cycle pulse: completed byte discarded because the holding register was full.
REQ-012 SHALL have port busy_o  output  1  FSM not in IDLE.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer reset to 1; all logic uses only the synchronized value rxs.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE->START SHALL occur when en_i=1 and rxs falls (previous rxs 1, current 0); div_i is latched into div_q at this transition, and div_i values <4 are latched as 4.
REQ-016 In START, the bit counter SHALL count clk cycles; at count floor(div_q/2) it samples rxs: 0 -> DATA with counter cleared, 1 -> IDLE (false start, no output).
REQ-017 In DATA, SHALL sample rxs every div_q cycles, 8 samples, LSB first, into a shift register; after the 8th sample -> STOP.
REQ-018 In STOP, SHALL sample rxs div_q cycles after the 8th data sample; 1 -> byte complete, 0 -> frame error; both -> IDLE.
REQ-019 IDLE SHALL not accept a new start until rxs has been seen high at least once after a frame error (break lockout).
REQ-020 On byte complete, data_o and valid_o=1 SHALL update on the next clk edge; latency from the first cycle of rxs=0 is floor(div_q/2) + 9*div_q + 1 clk cycles.
REQ-021 valid_o SHALL stay 1 and data_o stable until a cycle with valid_o=1 and ready_i=1; valid_o clears on the following edge.
REQ-022 If a byte completes while valid_o=1 and ready_i=0, SHALL discard the new byte, keep data_o, and pulse overrun_o for one cycle.
REQ-023 If a byte completes in the same cycle as a valid_o&ready_i handshake, SHALL load the new byte, keep valid_o=1, and not pulse overrun_o.
REQ-024 On frame error, SHALL pulse frame_err_o for one cycle and leave data_o and valid_o unchanged.
REQ-025 en_i=0 SHALL force the FSM to IDLE on the next edge, abandon any partial frame, and not affect data_o or valid_o.
REQ-026 Counters SHALL be DIV_W bits wide and never wrap: each sample point resets the counter to 0.
REQ-027 busy_o SHALL equal (state != IDLE).

Reset
REQ-028 On rst_n=0, SHALL immediately set state=IDLE, synchronizer flops=1, data_o=8'h00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, counters=0, break lockout cleared.
REQ-029 A reset asserted mid-frame SHALL drop the frame; the first full frame after release SHALL be received correctly.

Verification
REQ-030 div_i=16, en_i=1, ready_i=0, frame 0xA5 with stop=1 -> valid_o=1 and data_o=8'hA5 exactly 153 cycles after the synchronized falling edge; no error pulses.
REQ-031 rx_i low for 3 cycles then high, div_i=16 -> FSM returns to IDLE at the START sample, valid_o stays 0.
REQ-032 Frame 0x3C with stop bit 0 -> one-cycle frame_err_o pulse, valid_o unchanged; the next start is ignored until rx_i returns high.
REQ-033 Bytes 0x11 then 0x22 with ready_i=0 -> overrun_o pulses once and data_o=8'h11; repeating with ready_i=1 in the completion cycle of 0x22 -> data_o=8'h22, no overrun.
REQ-034 rst_n pulsed low during DATA of frame 0x55 -> all outputs at reset values; the following frame 0x81 is received as 8'h81.
REQ-035 div_i=2, frame 0x96 sent at 4 cycles per bit -> data_o=8'h96.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a runtime-programmable bit period.
//
// The serial input is synchronised into clk, a falling edge in IDLE opens a
// frame, the start bit is re-checked at its midpoint, eight data bits are
// taken LSB first one bit period apart, and the stop bit decides between a
// delivered byte and a frame error. Delivered bytes sit in a one-entry
// holding register with a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en_i         receiver enable; low aborts any frame in progress
//   div_i        clk cycles per UART bit (values below 4 are treated as 4)
//   rx_i         serial line, asynchronous, idle high
//   data_o       received byte
//   valid_o      data_o holds an unread byte
//   ready_i      consumer takes data_o when valid_o is high
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: completed byte dropped, holding register full
//   busy_o       receiver is inside a frame
module uart_rx #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             rxs_q, rxs_d;
    logic             rxs_prev_q, rxs_prev_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             lock_q, lock_d;

    logic [DIV_W-1:0] div_min;
    logic [DIV_W-1:0] half_m1;
    logic [DIV_W-1:0] full_m1;
    logic             fall;

    // Very short bit periods would make the start-bit midpoint meaningless.
    assign div_min = (div_i < DIV_W'(4)) ? DIV_W'(4) : div_i;

    // The cycle in which the fall is detected counts as cycle 0 of the start
    // bit, so START sees counter value k in cycle k+1 and the midpoint sample
    // lands floor(div/2) cycles after the fall.
    assign half_m1 = (div_q >> 1) - DIV_W'(1);
    assign full_m1 = div_q - DIV_W'(1);
    assign fall    = rxs_prev_q & ~rxs_q;

    // Next-state and datapath logic. Each sample point clears the counter so
    // it never needs to count beyond one bit period.
    always_comb begin
        state_d    = state_q;
        sync1_d    = rx_i;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        // A line seen high ends the lockout that follows a frame error.
        lock_d     = lock_q & ~rxs_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (fall && !lock_q) begin
                        state_d = START;
                        div_d   = div_min;
                    end
                end
                START: begin
                    if (cnt_q == half_m1) begin
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == full_m1) begin
                        cnt_d   = '0;
                        shift_d = {rxs_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == full_m1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (rxs_q) begin
                            // A same-cycle handshake frees the register in time.
                            if (!valid_q || ready_i) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            ferr_d = 1'b1;
                            lock_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register; the synchroniser resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            lock_q     <= lock_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives directed and random UART frames into uart_rx and checks
// every cycle against a frame-level reference model that works from sample
// times (fall + div/2 + k*div) rather than from receiver states.
module tb_uart_rx;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en_i;
    logic [DIV_W-1:0] div_i;
    logic             rx_i;
    logic             ready_i;
    logic [7:0]       data_o;
    logic             valid_o;
    logic             frame_err_o;
    logic             overrun_o;
    logic             busy_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int frame_start  = 0;
    int rise_cyc     = -1;
    int ferr_cnt     = 0;
    int ovr_cnt      = 0;
    bit valid_seen   = 1'b0;
    bit rand_ready   = 1'b0;

    // Reference model state, describing the current cycle.
    bit       m_s1, m_rxs, m_prev, m_busy, m_lock, m_valid, m_ferr, m_ovr;
    bit [7:0] m_data, m_bits;
    int       m_t0, m_div, mcyc;

    uart_rx #(.DIV_W(DIV_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .div_i       (div_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic modelReset();
        m_s1 = 1; m_rxs = 1; m_prev = 1; m_busy = 0; m_lock = 0;
        m_valid = 0; m_ferr = 0; m_ovr = 0; m_data = 8'h00; m_bits = 8'h00;
        m_t0 = 0; m_div = 4; mcyc = 0;
    endtask

    // Advance the model by one clock using the inputs seen this cycle.
    task automatic modelStep();
        bit       rxs, nbusy, nlock, nvalid, nferr, novr;
        bit [7:0] ndata;
        int       k, idx;
        rxs    = m_rxs;
        nbusy  = m_busy;
        nlock  = m_lock && !rxs;
        nvalid = m_valid;
        ndata  = m_data;
        nferr  = 0;
        novr   = 0;
        if (m_valid && ready_i) nvalid = 0;
        if (!en_i) begin
            nbusy = 0;
        end else if (!m_busy) begin
            if (!m_lock && m_prev && !rxs) begin
                nbusy = 1;
                m_t0  = mcyc;
                m_div = (div_i < 4) ? 4 : int'(div_i);
            end
        end else begin
            k = mcyc - m_t0 - m_div / 2;
            if (k >= 0 && (k % m_div) == 0) begin
                idx = k / m_div;
                if (idx == 0) begin
                    if (rxs) nbusy = 0;
                end else if (idx <= 8) begin
                    m_bits[idx-1] = rxs;
                end else begin
                    nbusy = 0;
                    if (rxs) begin
                        if (!m_valid || ready_i) begin
                            ndata  = m_bits;
                            nvalid = 1;
                        end else begin
                            novr = 1;
                        end
                    end else begin
                        nferr = 1;
                        nlock = 1;
                    end
                end
            end
        end
        m_busy = nbusy; m_lock = nlock; m_valid = nvalid; m_data = ndata;
        m_ferr = nferr; m_ovr = novr;
        m_prev = rxs;
        m_rxs  = m_s1;
        m_s1   = rx_i;
        mcyc++;
    endtask

    task automatic checkOutput();
        tests_run++;
        if (data_o !== m_data || valid_o !== m_valid || frame_err_o !== m_ferr ||
            overrun_o !== m_ovr || busy_o !== m_busy) begin
            tests_failed++;
            $display("[TB] FAIL cycle_cmp @%0d: got data=%h valid=%b ferr=%b ovr=%b busy=%b, expected data=%h valid=%b ferr=%b ovr=%b busy=%b",
                     cyc, data_o, valid_o, frame_err_o, overrun_o, busy_o,
                     m_data, m_valid, m_ferr, m_ovr, m_busy);
        end
    endtask

    task automatic checkLiteral(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Compare process: mid-cycle, compare then advance the model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) modelReset();
        checkOutput();
        if (frame_err_o === 1'b1) ferr_cnt++;
        if (overrun_o === 1'b1) ovr_cnt++;
        if (valid_o === 1'b1 && !valid_seen) rise_cyc = cyc;
        valid_seen = (valid_o === 1'b1);
        if (rst_n) modelStep();
    end

    function automatic logic nextReady(input bit pulse);
        if (rand_ready) return ($urandom_range(0, 3) == 0);
        return pulse;
    endfunction

    // Drive one frame, bit i of the line changing just after clock edge i.
    task automatic applyStimulus(input logic [7:0] data, input logic stop, input int period,
                                 input int ready_at, input int abort_at);
        int b;
        for (int i = 0; i < 10 * period; i++) begin
            @(posedge clk);
            #1;
            if (i == abort_at) return;
            if (i == 0) frame_start = cyc;
            b = i / period;
            rx_i    = (b == 0) ? 1'b0 : (b <= 8) ? data[b-1] : stop;
            ready_i = nextReady(i == ready_at);
        end
    endtask

    task automatic idleCycles(input int n, input logic level);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_i    = level;
            ready_i = nextReady(1'b0);
        end
    endtask

    task automatic consume();
        @(posedge clk); #1; ready_i = 1'b1;
        @(posedge clk); #1; ready_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int f0, o0, div, period;
        logic [7:0] byte_v;
        en_i = 1; rx_i = 1; ready_i = 0; div_i = 16;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkLiteral("reset_data", data_o, 8'h00);
        checkLiteral("reset_valid", valid_o, 0);
        checkLiteral("reset_busy", busy_o, 0);
        checkLiteral("reset_pulses", {frame_err_o, overrun_o}, 0);
        rst_n = 1'b1;
        idleCycles(5, 1);

        // 0xA5 at div 16: two synchroniser cycles plus 8 + 144 + 1.
        f0 = ferr_cnt; o0 = ovr_cnt; rise_cyc = -1;
        applyStimulus(8'hA5, 1, 16, -1, -1);
        idleCycles(10, 1);
        checkLiteral("a5_latency", rise_cyc - frame_start, 155);
        checkLiteral("a5_data", data_o, 8'hA5);
        checkLiteral("a5_model_data", m_data, 8'hA5);
        checkLiteral("a5_no_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        consume();
        checkLiteral("a5_consumed", valid_o, 0);

        // Three-cycle glitch is rejected at the start-bit midpoint.
        idleCycles(3, 0);
        idleCycles(3, 1);
        checkLiteral("glitch_busy", busy_o, 1);
        idleCycles(9, 1);
        checkLiteral("glitch_idle", busy_o, 0);
        checkLiteral("glitch_valid", valid_o, 0);
        idleCycles(30, 1);

        // Frame error then a held-low break; nothing starts until it rises.
        f0 = ferr_cnt;
        applyStimulus(8'h3C, 0, 16, -1, -1);
        idleCycles(30, 0);
        checkLiteral("ferr_pulses", ferr_cnt - f0, 1);
        checkLiteral("ferr_valid", valid_o, 0);
        checkLiteral("ferr_data", data_o, 8'hA5);
        checkLiteral("break_busy", busy_o, 0);
        idleCycles(10, 1);
        applyStimulus(8'h5A, 1, 16, -1, -1);
        idleCycles(5, 1);
        checkLiteral("after_break_data", data_o, 8'h5A);
        consume();

        // Overrun, then the same pair with a handshake in the completion cycle.
        o0 = ovr_cnt;
        applyStimulus(8'h11, 1, 16, -1, -1);
        idleCycles(5, 1);
        applyStimulus(8'h22, 1, 16, -1, -1);
        idleCycles(10, 1);
        checkLiteral("overrun_pulses", ovr_cnt - o0, 1);
        checkLiteral("overrun_data", data_o, 8'h11);
        checkLiteral("overrun_model_data", m_data, 8'h11);
        consume();
        o0 = ovr_cnt;
        applyStimulus(8'h11, 1, 16, -1, -1);
        idleCycles(5, 1);
        applyStimulus(8'h22, 1, 16, 154, -1);
        idleCycles(10, 1);
        checkLiteral("handoff_data", data_o, 8'h22);
        checkLiteral("handoff_valid", valid_o, 1);
        checkLiteral("handoff_no_overrun", ovr_cnt - o0, 0);
        consume();

        // Reset in the middle of the data bits of 0x55.
        applyStimulus(8'h55, 1, 16, -1, 60);
        rx_i = 1'b1; ready_i = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkLiteral("midreset_data", data_o, 8'h00);
        checkLiteral("midreset_busy", busy_o, 0);
        rst_n = 1'b1;
        idleCycles(20, 1);
        applyStimulus(8'h81, 1, 16, -1, -1);
        idleCycles(5, 1);
        checkLiteral("post_reset_data", data_o, 8'h81);
        consume();

        // A divisor below 4 behaves as 4.
        div_i = 2;
        applyStimulus(8'h96, 1, 4, -1, -1);
        idleCycles(5, 1);
        checkLiteral("div2_data", data_o, 8'h96);
        checkLiteral("div2_model_data", m_data, 8'h96);
        consume();

        // Random traffic: bytes, divisors, stop bits, ready, aborts, glitches.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            div    = $urandom_range(0, 12);
            period = (div < 4) ? 4 : div;
            div_i  = DIV_W'(div);
            byte_v = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(byte_v, 1, period, -1, $urandom_range(0, 10 * period - 1));
                en_i = 1'b0; rx_i = 1'b1;
                idleCycles(3, 1);
                en_i = 1'b1;
            end else begin
                applyStimulus(byte_v, ($urandom_range(0, 7) != 0), period, -1, -1);
            end
            if ($urandom_range(0, 9) == 0) idleCycles($urandom_range(1, 3), 0);
            idleCycles($urandom_range(1, 20), 1);
        end
        rand_ready = 1'b0;
        idleCycles(200, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
